// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose : queue entry layout and fetch constants used by instr_fetch and
//           fetch_queue.
// Contents: fetch_entry_t    {pc, instr} pair carried toward decode
//           INSTR_BYTES      PC increment per fetched instruction
//           RESET_PC_DEFAULT default fetch PC after reset
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch entries with flush
//
// Purpose : small in-order buffer between fetch and decode. The head entry is
//           read straight out of the storage registers, so dout never depends
//           combinationally on din.
// Ports   : clk, rst      clock, synchronous active-high reset
//           push, din     enqueue din this cycle (ignored when full and not popping)
//           pop           dequeue head this cycle (ignored when empty)
//           flush         drop every entry, including a same-cycle push
//           dout          head entry, valid while empty=0
//           empty, full   occupancy flags
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            pop_ok;
    logic            push_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A full queue may still accept a write when the head leaves this cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch-stage PC owner and instruction buffer toward decode
//
// Purpose : drives the instruction memory address from the PC register,
//           captures {pc, instr} on each memory response, advances the PC by
//           one instruction per capture and handles redirects from later stages.
// Ports   : clk, rst                         clock, synchronous active-high reset
//           imem_pc                          fetch address (the PC register)
//           imem_instr, imem_valid           memory response for imem_pc
//           redirect_valid, redirect_pc      replace the PC and flush wrong-path state
//           if_valid, if_ready               handshake toward decode
//           if_pc, if_instr                  queue head contents
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    logic [31:0]  pc;
    logic [31:0]  redirect_target;
    logic         pop;
    logic         push;
    logic         q_empty;
    logic         q_full;
    fetch_entry_t q_din;
    fetch_entry_t q_dout;

    // Targets are word aligned; low address bits from later stages are dropped.
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    assign if_valid = ~q_empty;
    assign pop      = if_valid & if_ready;
    // A response in a redirect cycle belongs to the wrong path and is discarded.
    assign push     = imem_valid & ~redirect_valid & (~q_full | pop);

    assign q_din.pc    = pc;
    assign q_din.instr = imem_instr;

    assign imem_pc  = pc;
    assign if_pc    = q_dout.pc;
    assign if_instr = q_dout.instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
        end else if (push) begin
            pc <= pc + INSTR_BYTES;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        imem_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .imem_valid     (imem_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        r;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eimem;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] popped[$];
    int          total = 0;
    int          bad   = 0;

    task automatic addv(input logic mv, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic r, input logic ev,
                        input logic [31:0] epc, input logic [31:0] einstr,
                        input logic [31:0] eimem);
        vec_t v;
        v.mv = mv; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.r = r;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.eimem = eimem;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, log the decode handshake at negedge, settle after posedge.
    task automatic cyc(input logic mv, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic r);
        imem_valid     = mv;
        imem_instr     = mv ? (32'h1000_0000 | imem_pc) : 32'hDEAD_BEEF;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rst            = r;
        @(negedge clk);
        if (if_valid === 1'b1 && if_ready === 1'b1) begin
            popped.push_back(if_pc);
            check("pop_pair", if_instr, 32'h1000_0000 | if_pc);
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pops[$];
    int          waited;
    logic        seen;

    initial begin
        rst = 1'b1; imem_valid = 1'b0; imem_instr = '0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        //   mv rdy rv rpc           rst ev  if_pc         if_instr      imem_pc
        // reset, then stream
        addv(0, 1, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0000_0000);
        addv(0, 1, 0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0000_0000);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0000, 32'h1000_0000, 32'h0000_0004);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0004, 32'h1000_0004, 32'h0000_0008);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0008, 32'h1000_0008, 32'h0000_000C);
        // backpressure for 6 cycles: fills to 2, PC frozen at head + 8
        addv(1, 0, 0, 32'h0,        0, 1, 32'h0000_0008, 32'h1000_0008, 32'h0000_0010);
        for (int i = 0; i < 5; i++)
            addv(1, 0, 0, 32'h0,    0, 1, 32'h0000_0008, 32'h1000_0008, 32'h0000_0010);
        // release: full with pop still accepts
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_000C, 32'h1000_000C, 32'h0000_0014);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0010, 32'h1000_0010, 32'h0000_0018);
        // redirect with 2 entries held, unaligned target
        addv(1, 0, 1, 32'h0000_0203, 0, 0, 32'h0,       32'h0,        32'h0000_0200);
        addv(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0000_0200);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0200, 32'h1000_0200, 32'h0000_0204);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0204, 32'h1000_0204, 32'h0000_0208);
        addv(1, 0, 0, 32'h0,        0, 1, 32'h0000_0204, 32'h1000_0204, 32'h0000_020C);
        // redirect with same-cycle pop of the old head
        addv(1, 1, 1, 32'h0000_0400, 0, 0, 32'h0,       32'h0,        32'h0000_0400);
        addv(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0000_0400);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0400, 32'h1000_0400, 32'h0000_0404);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0404, 32'h1000_0404, 32'h0000_0408);
        // wrap at the top of the address space
        addv(1, 1, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,       32'h0,        32'hFFFF_FFFC);
        addv(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC);
        addv(1, 1, 0, 32'h0,        0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0000, 32'h1000_0000, 32'h0000_0004);
        // fill, then reset together with a redirect
        addv(1, 0, 0, 32'h0,        0, 1, 32'h0000_0000, 32'h1000_0000, 32'h0000_0008);
        addv(1, 0, 1, 32'h0000_0800, 1, 0, 32'h0,       32'h0,        32'h0000_0000);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0000, 32'h1000_0000, 32'h0000_0004);
        // memory bubble mid-stream: PC holds
        addv(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0000_0004);
        addv(1, 1, 0, 32'h0,        0, 1, 32'h0000_0004, 32'h1000_0004, 32'h0000_0008);

        foreach (vecs[i]) begin
            cyc(vecs[i].mv, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].r);
            check($sformatf("v%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].ev});
            check($sformatf("v%0d_imem_pc", i), imem_pc, vecs[i].eimem);
            if (vecs[i].ev) begin
                check($sformatf("v%0d_if_pc", i), if_pc, vecs[i].epc);
                check($sformatf("v%0d_if_instr", i), if_instr, vecs[i].einstr);
            end
        end

        // Redirect while popping, then a memory bubble; target must appear within budget.
        cyc(1, 1, 1, 32'h0000_1001, 0);
        check("redir2_if_valid", {31'b0, if_valid}, 32'd0);
        check("redir2_imem_pc", imem_pc, 32'h0000_1000);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 8) begin
            cyc((waited != 0), 1'b0, 1'b0, 32'h0, 1'b0);
            waited++;
            seen = if_valid;
        end
        check("redir2_seen", {31'b0, seen}, 32'd1);
        check("redir2_latency", 32'(waited), 32'd2);
        check("redir2_if_pc", if_pc, 32'h0000_1000);
        check("redir2_if_instr", if_instr, 32'h1000_1000);

        // Every decode handshake in order: no duplicates, no stale or skipped PCs.
        exp_pops = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200, 32'h204, 32'h400, 32'h404,
                     32'hFFFF_FFFC, 32'h0, 32'h4};
        check("pop_count", 32'(popped.size()), 32'(exp_pops.size()));
        for (int i = 0; i < exp_pops.size() && i < popped.size(); i++)
            check($sformatf("pop%0d_pc", i), popped[i], exp_pops[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
